// File: rtl/music_box_sdram_arbiter.sv
// rtl/music_box_sdram_arbiter.sv - two-port round-robin arbiter in front of the SDRAM controller
// Optional watchdog on ISSUE/WAIT_DATA enabled by defining SDRAM_ARB_WATCHDOG_EN.
module music_box_sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [24:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic        p0_isWriting,
  output logic        p0_grant,
  output logic        p0_done,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic [24:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic        p1_isWriting,
  output logic        p1_grant,
  output logic        p1_done,
  output logic [15:0] p1_rdata,
  output logic [24:0] sdram_inputAddress,
  output logic [15:0] sdram_writeData,
  output logic        sdram_isWriting,
  output logic        sdram_inputValid,
  input  logic [15:0] sdram_readData,
  input  logic        sdram_outputValid,
  input  logic        sdram_recievedCommand,
  input  logic        sdram_isBusy,
  output logic        arb_timeout,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        p0_grant_q, p0_grant_d, p1_grant_q, p1_grant_d;
  logic        p0_done_q, p0_done_d, p1_done_q, p1_done_d;
  logic [15:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic [24:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic        pick_p1;
  logic        wd_fire;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            in_flight;

  assign in_flight = (state_q == ISSUE) || (state_q == WAIT_DATA);
  assign wd_fire   = in_flight && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d      = in_flight ? wd_q + 1'b1 : '0;
    timeout_d = timeout_q | wd_fire;
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb_timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // last_q == 1 means p1 was served last, so p0 wins a tie
  assign pick_p1 = p1_req && (!p0_req || !last_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    p0_grant_d = p0_grant_q;
    p1_grant_d = p1_grant_q;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (!sdram_isBusy && (p0_req || p1_req)) begin
          owner_d    = pick_p1;
          p0_grant_d = !pick_p1;
          p1_grant_d = pick_p1;
          addr_d     = pick_p1 ? p1_addr : p0_addr;
          wdata_d    = pick_p1 ? p1_wdata : p0_wdata;
          we_d       = pick_p1 ? p1_isWriting : p0_isWriting;
          valid_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (sdram_recievedCommand) begin
          valid_d = 1'b0;
          if (we_q) begin
            state_d   = DONE;
            p0_done_d = !owner_q;
            p1_done_d = owner_q;
          end else begin
            state_d = WAIT_DATA;
          end
        end else if (wd_fire) begin
          valid_d   = 1'b0;
          state_d   = DONE;
          p0_done_d = !owner_q;
          p1_done_d = owner_q;
        end
      end
      WAIT_DATA: begin
        if (sdram_outputValid) begin
          if (owner_q) p1_rdata_d = sdram_readData;
          else         p0_rdata_d = sdram_readData;
          state_d   = DONE;
          p0_done_d = !owner_q;
          p1_done_d = owner_q;
        end else if (wd_fire) begin
          state_d   = DONE;
          p0_done_d = !owner_q;
          p1_done_d = owner_q;
        end
      end
      DONE: begin
        p0_grant_d = 1'b0;
        p1_grant_d = 1'b0;
        last_d     = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      p0_grant_q <= 1'b0;
      p1_grant_q <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      p0_grant_q <= p0_grant_d;
      p1_grant_q <= p1_grant_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      valid_q    <= valid_d;
    end
  end

  assign p0_grant           = p0_grant_q;
  assign p1_grant           = p1_grant_q;
  assign p0_done            = p0_done_q;
  assign p1_done            = p1_done_q;
  assign p0_rdata           = p0_rdata_q;
  assign p1_rdata           = p1_rdata_q;
  assign sdram_inputAddress = addr_q;
  assign sdram_writeData    = wdata_q;
  assign sdram_isWriting    = we_q;
  assign sdram_inputValid   = valid_q;
  assign arb_state          = state_q;

endmodule

// File: tb/tb_music_box_sdram_arbiter.sv
// tb/tb_music_box_sdram_arbiter.sv - directed self-checking bench for music_box_sdram_arbiter
module tb_music_box_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p1_req;
  logic [24:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_isWriting, p1_isWriting;
  logic        p0_grant, p1_grant, p0_done, p1_done;
  logic [15:0] p0_rdata, p1_rdata;
  logic [24:0] sdram_inputAddress;
  logic [15:0] sdram_writeData;
  logic        sdram_isWriting, sdram_inputValid;
  logic [15:0] sdram_readData;
  logic        sdram_outputValid, sdram_recievedCommand, sdram_isBusy;
  logic        arb_timeout;
  logic [1:0]  arb_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  music_box_sdram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock_50Mhz(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_isWriting(p0_isWriting),
    .p0_grant(p0_grant), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_isWriting(p1_isWriting),
    .p1_grant(p1_grant), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .sdram_inputAddress(sdram_inputAddress), .sdram_writeData(sdram_writeData),
    .sdram_isWriting(sdram_isWriting), .sdram_inputValid(sdram_inputValid),
    .sdram_readData(sdram_readData), .sdram_outputValid(sdram_outputValid),
    .sdram_recievedCommand(sdram_recievedCommand), .sdram_isBusy(sdram_isBusy),
    .arb_timeout(arb_timeout), .arb_state(arb_state)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [127:0] got;
    reset = 1'b1;
    tick();
    tick();
    got = {p0_grant, p1_grant, p0_done, p1_done, p0_rdata, p1_rdata, sdram_inputAddress,
           sdram_writeData, sdram_isWriting, sdram_inputValid, arb_timeout, arb_state};
    n_checks++;
    if (got !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    reset = 1'b0;
  endtask

  task automatic test_write();
    tick();
    p0_req = 1'b1; p0_addr = 25'h0000010; p0_wdata = 16'hBEEF; p0_isWriting = 1'b1;
    tick();
    n_checks++;
    if ({sdram_inputValid, p0_grant, p1_grant, arb_state} !== 5'b11001) begin
      n_fail++;
      $display("FAIL write_c1_ctrl: got %b expected 11001",
               {sdram_inputValid, p0_grant, p1_grant, arb_state});
    end
    n_checks++;
    if ({sdram_inputAddress, sdram_writeData, sdram_isWriting} !== {25'h0000010, 16'hBEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL write_c1_cmd: got %h/%h/%b expected 0000010/beef/1",
               sdram_inputAddress, sdram_writeData, sdram_isWriting);
    end
    p0_req = 1'b0;
    tick();
    n_checks++;
    if (sdram_inputValid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_c2_valid: got %b expected 1", sdram_inputValid);
    end
    tick();
    n_checks++;
    if ({sdram_inputValid, p0_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL write_c3: got valid/done %b expected 10", {sdram_inputValid, p0_done});
    end
    sdram_recievedCommand = 1'b1;
    tick();
    sdram_recievedCommand = 1'b0;
    n_checks++;
    if ({p0_done, p1_done, sdram_inputValid, arb_state} !== 5'b10011) begin
      n_fail++;
      $display("FAIL write_c4_done: got %b expected 10011",
               {p0_done, p1_done, sdram_inputValid, arb_state});
    end
    tick();
    n_checks++;
    if ({p0_done, p0_grant, arb_state, sdram_inputAddress} !== {4'b0000, 25'h0000010}) begin
      n_fail++;
      $display("FAIL write_c5_idle: got done=%b grant=%b state=%0d addr=%h expected 0 0 0 0000010",
               p0_done, p0_grant, arb_state, sdram_inputAddress);
    end
  endtask

  task automatic test_read();
    p1_req = 1'b1; p1_addr = 25'h1ABCDEF; p1_wdata = 16'h0000; p1_isWriting = 1'b0;
    tick();
    n_checks++;
    if ({p1_grant, p0_grant, sdram_inputValid, sdram_isWriting, sdram_inputAddress} !==
        {4'b1010, 25'h1ABCDEF}) begin
      n_fail++;
      $display("FAIL read_issue: got g1=%b g0=%b v=%b we=%b addr=%h expected 1 0 1 0 1abcdef",
               p1_grant, p0_grant, sdram_inputValid, sdram_isWriting, sdram_inputAddress);
    end
    sdram_recievedCommand = 1'b1;
    p1_req = 1'b0;
    tick();
    sdram_recievedCommand = 1'b0;
    n_checks++;
    if ({arb_state, sdram_inputValid, p1_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL read_wait: got state=%0d valid=%b done=%b expected 2 0 0",
               arb_state, sdram_inputValid, p1_done);
    end
    tick();
    sdram_outputValid = 1'b1; sdram_readData = 16'h1234;
    tick();
    sdram_outputValid = 1'b0; sdram_readData = 16'h0000;
    n_checks++;
    if ({p1_done, p0_done, p1_rdata, p0_rdata} !== {2'b10, 16'h1234, 16'h0000}) begin
      n_fail++;
      $display("FAIL read_done: got done1=%b done0=%b rdata1=%h rdata0=%h expected 1 0 1234 0000",
               p1_done, p0_done, p1_rdata, p0_rdata);
    end
    tick();
    n_checks++;
    if ({p1_done, p1_grant, arb_state} !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_end: got done=%b grant=%b state=%0d expected 0 0 0",
               p1_done, p1_grant, arb_state);
    end
  endtask

  task automatic test_round_robin();
    int order[4];
    int n_gr = 0;
    int dones = 0;
    logic both = 1'b0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    logic [15:0] rd_val = 16'h5A00;
    p0_req = 1'b1; p0_addr = 25'h0000100; p0_isWriting = 1'b0;
    p1_req = 1'b1; p1_addr = 25'h0000200; p1_wdata = 16'hCAFE; p1_isWriting = 1'b1;
    for (int c = 0; c < 80 && dones < 4; c++) begin
      tick();
      if (p0_grant && p1_grant) both = 1'b1;
      if (p0_grant && !prev0 && n_gr < 4) begin order[n_gr] = 0; n_gr++; end
      if (p1_grant && !prev1 && n_gr < 4) begin order[n_gr] = 1; n_gr++; end
      prev0 = p0_grant;
      prev1 = p1_grant;
      if (p0_done || p1_done) dones++;
      sdram_recievedCommand = sdram_inputValid;
      if (arb_state == 2'd2) begin
        sdram_outputValid = 1'b1; sdram_readData = rd_val; rd_val = rd_val + 16'h1;
      end else begin
        sdram_outputValid = 1'b0;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    sdram_recievedCommand = 1'b0; sdram_outputValid = 1'b0;
    tick();
    n_checks++;
    if (dones !== 4 || n_gr !== 4) begin
      n_fail++;
      $display("FAIL rr_count: got dones=%0d grants=%0d expected 4 4", dones, n_gr);
    end
    n_checks++;
    if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
      n_fail++;
      $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", order[0], order[1], order[2], order[3]);
    end
    n_checks++;
    if (both !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_exclusive: got both-grants=%b expected 0", both);
    end
    n_checks++;
    if (p0_rdata !== 16'h5A01 || p1_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL rr_rdata: got p0=%h p1=%h expected 5a01 1234", p0_rdata, p1_rdata);
    end
  endtask

  task automatic test_busy();
    logic bad = 1'b0;
    sdram_isBusy = 1'b1;
    p0_req = 1'b1; p0_addr = 25'h0000300; p0_wdata = 16'h0F0F; p0_isWriting = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (p0_grant || p1_grant || sdram_inputValid || arb_state != 2'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_hold: got activity=%b expected 0", bad);
    end
    sdram_isBusy = 1'b0;
    tick();
    n_checks++;
    if ({p0_grant, sdram_inputValid, arb_state} !== 4'b1101) begin
      n_fail++;
      $display("FAIL busy_release: got %b expected 1101", {p0_grant, sdram_inputValid, arb_state});
    end
    sdram_recievedCommand = 1'b1;
    p0_req = 1'b0;
    tick();
    sdram_recievedCommand = 1'b0;
    n_checks++;
    if (p0_done !== 1'b1 || p0_rdata !== 16'h5A01) begin
      n_fail++;
      $display("FAIL busy_done: got done=%b rdata=%h expected 1 5a01", p0_done, p0_rdata);
    end
    tick();
  endtask

  task automatic test_watchdog();
    logic bad = 1'b0;
    p0_req = 1'b1; p0_addr = 25'h0000400; p0_isWriting = 1'b0;
    tick();
    p0_req = 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
    for (int i = 1; i <= 8; i++) begin
      if (!sdram_inputValid || arb_timeout || arb_state != 2'd1) bad = 1'b1;
      if (i < 8) tick();
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_issue: got early-exit=%b expected 0", bad);
    end
    tick();
    n_checks++;
    if ({arb_timeout, p0_done, sdram_inputValid, arb_state} !== 5'b11011) begin
      n_fail++;
      $display("FAIL wd_fire: got %b expected 11011",
               {arb_timeout, p0_done, sdram_inputValid, arb_state});
    end
    tick();
    n_checks++;
    if ({arb_timeout, p0_done, arb_state, p0_rdata} !== {4'b1000, 16'h5A01}) begin
      n_fail++;
      $display("FAIL wd_idle: got to=%b done=%b state=%0d rdata=%h expected 1 0 0 5a01",
               arb_timeout, p0_done, arb_state, p0_rdata);
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (!sdram_inputValid || arb_timeout || p0_done || arb_state != 2'd1) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL nowd_wait: got early-exit=%b expected 0", bad);
    end
    sdram_recievedCommand = 1'b1;
    tick();
    sdram_recievedCommand = 1'b0;
    tick();
    sdram_outputValid = 1'b1; sdram_readData = 16'h7777;
    tick();
    sdram_outputValid = 1'b0;
    n_checks++;
    if ({arb_timeout, p0_done, p0_rdata} !== {2'b01, 16'h7777}) begin
      n_fail++;
      $display("FAIL nowd_done: got to=%b done=%b rdata=%h expected 0 1 7777",
               arb_timeout, p0_done, p0_rdata);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    logic saw_done = 1'b0;
    p1_req = 1'b1; p1_addr = 25'h0000500; p1_isWriting = 1'b0;
    tick();
    sdram_recievedCommand = 1'b1;
    p1_req = 1'b0;
    tick();
    sdram_recievedCommand = 1'b0;
    n_checks++;
    if (arb_state !== 2'd2) begin
      n_fail++;
      $display("FAIL rstmid_wait: got state=%0d expected 2", arb_state);
    end
    #2 reset = 1'b1;
    tick();
    got = {p0_grant, p1_grant, p0_done, p1_done, p0_rdata, p1_rdata, sdram_inputAddress,
           sdram_writeData, sdram_isWriting, sdram_inputValid, arb_timeout, arb_state};
    n_checks++;
    if (got !== 128'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h expected 0", got);
    end
    reset = 1'b0;
    p0_req = 1'b1; p0_isWriting = 1'b1; p0_addr = 25'h0000600;
    p1_req = 1'b1; p1_isWriting = 1'b1;
    tick();
    if (p0_done || p1_done) saw_done = 1'b1;
    n_checks++;
    if ({p0_grant, p1_grant, saw_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_rearb: got g0=%b g1=%b done=%b expected 1 0 0", p0_grant, p1_grant, saw_done);
    end
    sdram_recievedCommand = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    sdram_recievedCommand = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    p0_req = 1'b0; p0_addr = '0; p0_wdata = '0; p0_isWriting = 1'b0;
    p1_req = 1'b0; p1_addr = '0; p1_wdata = '0; p1_isWriting = 1'b0;
    sdram_readData = '0; sdram_outputValid = 1'b0;
    sdram_recievedCommand = 1'b0; sdram_isBusy = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_busy();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
